// File: rtl/clk_gate_en_ctrl.sv
// Enable/test-enable controller for a single clock-gating cell: gates the
// module clock after a programmable idle interval, restores it on activity.
module clk_gate_en_ctrl #(
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned CNT_W       = 5
) (
  input  logic forever_cpuclk,
  input  logic cpurst_b,
  input  logic module_busy,
  input  logic wake_req,
  input  logic sleep_req,
  input  logic pad_yy_gate_clk_en_b,
  input  logic pad_yy_test_mode,
  output logic clk_en,
  output logic clk_te,
  output logic sleep_ack,
  output logic wake_done,
  output logic gated
);

  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_IDLE  = 2'd1,
    S_GATED = 2'd2,
    S_WAKE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_en_q, clk_en_d;
  logic             sleep_ack_q, sleep_ack_d;
  logic             wake_done_q, wake_done_d;
  logic             gated_q, gated_d;
  logic             wake_c;

  assign wake_c = module_busy | wake_req | pad_yy_gate_clk_en_b;

  // Saturating increment: the shared counter never wraps.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Next-state and next-output decode; every output is taken from the next
  // state so the gating cell sees a pure flop output.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_RUN: begin
        cnt_d = '0;
        if (!wake_c) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (wake_c) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else if (cnt_q == IDLE_LAST) begin
          state_d = S_GATED;
          cnt_d   = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      S_GATED: begin
        if (wake_c) begin
          state_d = S_WAKE;
          cnt_d   = '0;
        end
      end
      S_WAKE: begin
        if (cnt_q == WAKE_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    endcase

    clk_en_d    = (state_d != S_GATED);
    gated_d     = (state_d == S_GATED);
    sleep_ack_d = (state_d == S_GATED) & sleep_req;
    // High during the last WAKE cycle, i.e. the one that hands over to RUN.
    wake_done_d = (state_d == S_WAKE) && (cnt_d == WAKE_LAST);
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q     <= S_RUN;
      cnt_q       <= '0;
      clk_en_q    <= 1'b1;
      sleep_ack_q <= 1'b0;
      wake_done_q <= 1'b0;
      gated_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clk_en_q    <= clk_en_d;
      sleep_ack_q <= sleep_ack_d;
      wake_done_q <= wake_done_d;
      gated_q     <= gated_d;
    end
  end

  assign clk_en    = clk_en_q;
  assign sleep_ack = sleep_ack_q;
  assign wake_done = wake_done_q;
  assign gated     = gated_q;
  // Test mode forces the gating cell open with no latency.
  assign clk_te    = pad_yy_test_mode;

endmodule

// File: tb/tb_clk_gate_en_ctrl.sv
// Directed plus randomized bench for clk_gate_en_ctrl against a cycle model
// expressed as quiet-run length, gated flag and remaining wake cycles.
module tb_clk_gate_en_ctrl;

  localparam int IDLE_CYCLES = 16;
  localparam int WAKE_CYCLES = 2;

  logic forever_cpuclk = 1'b0;
  logic cpurst_b;
  logic module_busy, wake_req, sleep_req, pad_yy_gate_clk_en_b, pad_yy_test_mode;
  logic clk_en, clk_te, sleep_ack, wake_done, gated;

  int tests = 0;
  int fails = 0;

  int m_quiet, m_rem;
  bit m_gated, m_ack;

  clk_gate_en_ctrl #(.IDLE_CYCLES(IDLE_CYCLES), .WAKE_CYCLES(WAKE_CYCLES), .CNT_W(5)) dut (
    .forever_cpuclk       (forever_cpuclk),
    .cpurst_b             (cpurst_b),
    .module_busy          (module_busy),
    .wake_req             (wake_req),
    .sleep_req            (sleep_req),
    .pad_yy_gate_clk_en_b (pad_yy_gate_clk_en_b),
    .pad_yy_test_mode     (pad_yy_test_mode),
    .clk_en               (clk_en),
    .clk_te               (clk_te),
    .sleep_ack            (sleep_ack),
    .wake_done            (wake_done),
    .gated                (gated)
  );

  always #5 forever_cpuclk = ~forever_cpuclk;

  task automatic check(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_quiet = 0;
    m_rem   = 0;
    m_gated = 0;
    m_ack   = 0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_clk_en"},    clk_en,    logic'(!m_gated));
    check({tag, "_gated"},     gated,     logic'(m_gated));
    check({tag, "_sleep_ack"}, sleep_ack, logic'(m_ack));
    check({tag, "_wake_done"}, wake_done, logic'(m_rem == 1));
    check({tag, "_clk_te"},    clk_te,    pad_yy_test_mode);
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic step(input string tag);
    bit w;
    @(posedge forever_cpuclk);
    w = module_busy | wake_req | pad_yy_gate_clk_en_b;
    if (m_rem > 0) begin
      m_rem--;
      m_quiet = 0;
    end else if (m_gated) begin
      if (w) begin
        m_gated = 0;
        m_rem   = WAKE_CYCLES;
      end
    end else begin
      m_quiet = w ? 0 : m_quiet + 1;
      if (m_quiet == IDLE_CYCLES + 1) begin
        m_gated = 1;
        m_quiet = 0;
      end
    end
    m_ack = m_gated && sleep_req;
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset(input string tag);
    #2 cpurst_b = 1'b0;
    #1;
    model_reset();
    check({tag, "_rst_clk_en"}, clk_en, 1'b1);
    check({tag, "_rst_gated"},  gated,  1'b0);
    check({tag, "_rst_ack"},    sleep_ack, 1'b0);
    compare_all({tag, "_rst"});
    @(negedge forever_cpuclk);
    cpurst_b = 1'b1;
  endtask

  initial begin
    cpurst_b = 1'b0;
    module_busy = 1'b1;
    wake_req = 1'b0;
    sleep_req = 1'b0;
    pad_yy_gate_clk_en_b = 1'b0;
    pad_yy_test_mode = 1'b0;
    model_reset();
    #12;
    check("reset_clk_en", clk_en, 1'b1);
    check("reset_gated", gated, 1'b0);
    check("reset_ack", sleep_ack, 1'b0);
    check("reset_done", wake_done, 1'b0);
    @(negedge forever_cpuclk);
    cpurst_b = 1'b1;
    repeat (3) step("run_busy");

    // Idle gating with sleep_req already pending.
    module_busy = 1'b0;
    sleep_req = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      step("idle");
      if (i == 16) check("idle_en_c16", clk_en, 1'b1);
    end
    check("idle_en_c17", clk_en, 1'b0);
    check("idle_gated_c17", gated, 1'b1);
    check("idle_ack_c17", sleep_ack, 1'b1);
    repeat (2) step("gated_hold");

    // Wake request: ack and gated drop together, clock back in one cycle.
    wake_req = 1'b1;
    step("wake_n1");
    check("wake_en_n1", clk_en, 1'b1);
    check("wake_gated_n1", gated, 1'b0);
    check("wake_ack_n1", sleep_ack, 1'b0);
    wake_req = 1'b0;
    step("wake_n2");
    check("wake_done_n2", wake_done, 1'b1);
    step("wake_n3");
    check("wake_done_n3", wake_done, 1'b0);
    sleep_req = 1'b0;

    // Activity exactly at the terminal idle count.
    module_busy = 1'b1;
    step("coll_pre");
    module_busy = 1'b0;
    repeat (16) step("coll_idle");
    module_busy = 1'b1;
    step("coll_hit");
    check("coll_en", clk_en, 1'b1);
    module_busy = 1'b0;
    repeat (16) step("coll_again");
    check("coll_en_after", clk_en, 1'b1);
    step("coll_gate");
    check("coll_gate_en", clk_en, 1'b0);

    // Test mode is a zero-latency passthrough.
    pad_yy_test_mode = 1'b1;
    #1 check("te_high", clk_te, 1'b1);
    pad_yy_test_mode = 1'b0;
    #1 check("te_low", clk_te, 1'b0);

    // Global gating disable from GATED still passes through WAKE.
    pad_yy_gate_clk_en_b = 1'b1;
    step("pad_n1");
    check("pad_en_n1", clk_en, 1'b1);
    step("pad_n2");
    check("pad_done_n2", wake_done, 1'b1);
    repeat (20) step("pad_hold");
    check("pad_hold_en", clk_en, 1'b1);
    pad_yy_gate_clk_en_b = 1'b0;

    // Reset while gated, then while partway through WAKE.
    module_busy = 1'b0;
    repeat (18) step("pre_rst_gate");
    check("pre_rst_gated", gated, 1'b1);
    do_reset("mid_gated");
    module_busy = 1'b1;
    repeat (4) step("post_rst_run");
    module_busy = 1'b0;
    repeat (18) step("pre_rst_wake");
    module_busy = 1'b1;
    step("rst_wake_enter");
    do_reset("mid_wake");
    repeat (3) step("post_rst_wake");

    // Randomized segments alternating quiet and busy traffic.
    for (int seg = 0; seg < 30; seg++) begin
      bit quiet;
      quiet = ($urandom_range(0, 1) == 1);
      for (int c = 0; c < 30; c++) begin
        module_busy = quiet ? ($urandom_range(0, 49) == 0) : ($urandom_range(0, 1) == 1);
        wake_req = ($urandom_range(0, 39) == 0);
        pad_yy_gate_clk_en_b = ($urandom_range(0, 59) == 0);
        if ($urandom_range(0, 7) == 0) sleep_req = ~sleep_req;
        pad_yy_test_mode = ($urandom_range(0, 9) == 0);
        step("rand");
        if ($urandom_range(0, 299) == 0) do_reset("rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
